// File: rtl/input_cond_pkg.sv
// Shared types and constants for the input conditioner slice.
package input_cond_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } press_state_t;

    localparam int DEBOUNCE_SIM = 8;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a stable-count debouncer for a single raw input.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic raw,
    output logic db
);
    import input_cond_pkg::*;

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= raw;
            s  <= s1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (s == db) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            db  <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises, debounces and captures board switches/pushbutton for the cpu core.
// Define INPUT_COND_AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module input_conditioner #(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef INPUT_COND_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic            clk,
    input  logic            sync_rst,
    input  logic [N_SW-1:0] sw_raw,
    input  logic            psw_raw,
    output logic [N_SW-1:0] sw_db,
    output logic            psw_db,
    output logic            psw_press,
    output logic [N_SW-1:0] cap_data,
    output logic            cap_valid,
    input  logic            cap_ack,
    output logic            cap_overrun
);
    import input_cond_pkg::*;

    press_state_t state;
    logic         press_fire;

    for (genvar i = 0; i <= N_SW; i++) begin : g_db
        if (i < N_SW) begin : g_sw
            debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk      (clk),
                .sync_rst (sync_rst),
                .raw      (sw_raw[i]),
                .db       (sw_db[i])
            );
        end else begin : g_psw
            debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk      (clk),
                .sync_rst (sync_rst),
                .raw      (psw_raw),
                .db       (psw_db)
            );
        end
    end

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = cnt_width(RPT_MAX);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
    logic          rpt_hit;

    assign rpt_hit = rpt_first ? (rpt_cnt == RW'(REPEAT_DELAY - 1))
                               : (rpt_cnt == RW'(REPEAT_PERIOD - 1));

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; any exit from HELD rearms.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == HELD && psw_db) begin
            if (rpt_hit) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end else begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end
    end

    assign press_fire = psw_db && ((state == IDLE) || rpt_hit);
`else
    assign press_fire = psw_db && (state == IDLE);
`endif

    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            state     <= IDLE;
            psw_press <= 1'b0;
        end else begin
            state     <= psw_db ? HELD : IDLE;
            psw_press <= press_fire;
        end
    end

    // A press with an unconsumed value pending (and no ack alongside) is flagged, not stored.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            cap_data    <= '0;
            cap_valid   <= 1'b0;
            cap_overrun <= 1'b0;
        end else if (psw_press) begin
            if (!cap_valid || cap_ack) begin
                cap_data  <= sw_db;
                cap_valid <= 1'b1;
            end else begin
                cap_overrun <= 1'b1;
            end
        end else if (cap_ack && cap_valid) begin
            cap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a window-based reference model.
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int DEB         = DEBOUNCE_SIM;
    localparam int RPT_DELAY   = 20;
    localparam int RPT_PERIOD  = 10;

    logic       clk;
    logic       sync_rst;
    logic [3:0] sw_raw;
    logic       psw_raw;
    logic [3:0] sw_db;
    logic       psw_db;
    logic       psw_press;
    logic [3:0] cap_data;
    logic       cap_valid;
    logic       cap_ack;
    logic       cap_overrun;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;

    input_conditioner #(
        .N_SW            (4),
        .DEBOUNCE_CYCLES (DEB)
`ifdef INPUT_COND_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RPT_DELAY),
        .REPEAT_PERIOD   (RPT_PERIOD)
`endif
    ) dut (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .sw_raw      (sw_raw),
        .psw_raw     (psw_raw),
        .sw_db       (sw_db),
        .psw_db      (psw_db),
        .psw_press   (psw_press),
        .cap_data    (cap_data),
        .cap_valid   (cap_valid),
        .cap_ack     (cap_ack),
        .cap_overrun (cap_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a debounced bit flips once the last DEB synchronised samples all disagree with it.
    logic [3:0] m_sw_db, m_cap_data;
    logic       m_psw_db, m_press, m_valid, m_ovr, m_prev_psw;
    int         m_held;
    logic [4:0] raw_hist[$];
    logic [4:0] s_hist[$];

    always @(posedge clk) begin : ref_model
        logic [4:0] s_now;
        logic [4:0] db_pre;
        logic [4:0] db_new;
        logic       press_new;
        bit         flip;
        if (!sync_rst) begin
            raw_hist.delete();
            s_hist.delete();
            m_sw_db = '0; m_psw_db = 1'b0; m_press = 1'b0;
            m_cap_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
            m_prev_psw = 1'b0; m_held = 0;
        end else begin
            s_now = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 5'd0;
            raw_hist.push_back({psw_raw, sw_raw});
            if (raw_hist.size() > 2) void'(raw_hist.pop_front());
            s_hist.push_back(s_now);
            if (s_hist.size() > DEB) void'(s_hist.pop_front());
            db_pre = {m_psw_db, m_sw_db};
            db_new = db_pre;
            if (s_hist.size() == DEB) begin
                for (int b = 0; b < 5; b++) begin
                    flip = 1'b1;
                    foreach (s_hist[j]) if (s_hist[j][b] == db_pre[b]) flip = 1'b0;
                    if (flip) db_new[b] = s_now[b];
                end
            end
            press_new = db_pre[4] && !m_prev_psw;
`ifdef INPUT_COND_AUTOREPEAT_EN
            if (db_pre[4] && m_prev_psw) begin
                m_held++;
                if (m_held >= RPT_DELAY && (m_held - RPT_DELAY) % RPT_PERIOD == 0)
                    press_new = 1'b1;
            end else begin
                m_held = 0;
            end
`endif
            if (m_press) begin
                if (!m_valid || cap_ack) begin
                    m_cap_data = m_sw_db;
                    m_valid    = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (cap_ack && m_valid) begin
                m_valid = 1'b0;
            end
            m_prev_psw = db_pre[4];
            m_press    = press_new;
            {m_psw_db, m_sw_db} = db_new;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (psw_press === 1'b1) pulse_cnt++;
        checkOutput("sw_db",       sw_db,       m_sw_db);
        checkOutput("psw_db",      psw_db,      m_psw_db);
        checkOutput("psw_press",   psw_press,   m_press);
        checkOutput("cap_data",    cap_data,    m_cap_data);
        checkOutput("cap_valid",   cap_valid,   m_valid);
        checkOutput("cap_overrun", cap_overrun, m_ovr);
    endtask

    task automatic applyStimulus(input logic [3:0] sw, input logic psw, input logic ack, input int n);
        sw_raw  = sw;
        psw_raw = psw;
        cap_ack = ack;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        sync_rst = 1'b0;
        sw_raw   = 4'hF;
        psw_raw  = 1'b1;
        cap_ack  = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checkOutput("rst_sw_db",     sw_db,     4'h0);
        checkOutput("rst_psw_press", psw_press, 1'b0);
        checkOutput("rst_cap_valid", cap_valid, 1'b0);

        // Release with inputs already asserted: debounced after 10 edges, pulse on the 11th.
        sync_rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 9)  checkOutput("rel_sw_db_9",  sw_db, 4'h0);
            if (k == 10) checkOutput("rel_sw_db_10", sw_db, 4'hF);
            if (k == 10) checkOutput("rel_press_10", psw_press, 1'b0);
            if (k == 11) checkOutput("rel_press_11", psw_press, 1'b1);
            if (k == 12) checkOutput("rel_press_12", psw_press, 1'b0);
        end

        applyStimulus(4'h0, 1'b0, 1'b0, 15);
        applyStimulus(4'h0, 1'b0, 1'b1, 1);

        applyStimulus(4'h4, 1'b0, 1'b0, 5);
        applyStimulus(4'h0, 1'b0, 1'b0, 12);
        checkOutput("glitch_sw_db", sw_db, 4'h0);
        applyStimulus(4'h4, 1'b0, 1'b0, 9);
        checkOutput("stable_sw_db_9", sw_db, 4'h0);
        applyStimulus(4'h4, 1'b0, 1'b0, 1);
        checkOutput("stable_sw_db_10", sw_db, 4'h4);

        applyStimulus(4'hA, 1'b0, 1'b0, 12);
        pulse_cnt = 0;
        applyStimulus(4'hA, 1'b1, 1'b0, 20);
        checkOutput("cap_pulses", pulse_cnt, 1);
        checkOutput("cap_data_A", cap_data, 4'hA);
        checkOutput("cap_valid_1", cap_valid, 1'b1);
        applyStimulus(4'hA, 1'b0, 1'b0, 12);
        applyStimulus(4'hA, 1'b0, 1'b1, 1);
        checkOutput("ack_valid_0", cap_valid, 1'b0);

        applyStimulus(4'hA, 1'b1, 1'b0, 20);
        applyStimulus(4'hA, 1'b0, 1'b0, 12);
        applyStimulus(4'h5, 1'b0, 1'b0, 12);
        applyStimulus(4'h5, 1'b1, 1'b0, 20);
        applyStimulus(4'h5, 1'b0, 1'b0, 12);
        checkOutput("ovr_data_A", cap_data, 4'hA);
        checkOutput("ovr_set", cap_overrun, 1'b1);
        applyStimulus(4'h5, 1'b0, 1'b1, 1);
        checkOutput("ovr_sticky", cap_overrun, 1'b1);

        applyStimulus(4'h5, 1'b1, 1'b0, 20);
        applyStimulus(4'h5, 1'b0, 1'b0, 12);
        applyStimulus(4'h3, 1'b0, 1'b0, 12);
        applyStimulus(4'h3, 1'b1, 1'b0, 11);
        applyStimulus(4'h3, 1'b1, 1'b1, 1);
        checkOutput("sim_data_3", cap_data, 4'h3);
        checkOutput("sim_valid", cap_valid, 1'b1);
        checkOutput("sim_ovr", cap_overrun, 1'b1);
        applyStimulus(4'h3, 1'b1, 1'b0, 8);
        applyStimulus(4'h3, 1'b0, 1'b0, 12);

`ifdef INPUT_COND_AUTOREPEAT_EN
        applyStimulus(4'h3, 1'b0, 1'b1, 1);
        applyStimulus(4'h3, 1'b1, 1'b0, 11);
        pulse_cnt = 0;
        applyStimulus(4'h3, 1'b1, 1'b0, 45);
        checkOutput("rpt_held_pulses", pulse_cnt, 3);
        pulse_cnt = 0;
        applyStimulus(4'h3, 1'b0, 1'b0, 20);
        checkOutput("rpt_release_pulses", pulse_cnt, 1);
`endif

        // Random segments of held levels; short holds exercise glitch rejection.
        for (int seg = 0; seg < 250; seg++) begin
            int n;
            sw_raw  = 4'($urandom_range(0, 15));
            psw_raw = 1'($urandom_range(0, 1));
            n       = $urandom_range(1, 16);
            for (int k = 0; k < n; k++) begin
                cap_ack = ($urandom_range(0, 3) == 0);
                tick();
            end
            if (seg == 120) begin
                sync_rst = 1'b0;
                tick();
                tick();
                sync_rst = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
